// File: rtl/tms_multi_collector_pkg.sv
// Shared types and constants for the multi-channel section collector.
package tms_multi_collector_types;

    // Frame phases: A gathers the channels, B emits the result.
    typedef enum logic {
        SECTION_A = 1'b0,
        SECTION_B = 1'b1
    } sections_t;

    // Combine modes selectable through ACC_MODE.
    localparam int ACC_WRAP = 0;
    localparam int ACC_SAT  = 1;
    localparam int ACC_MAX  = 2;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tms_multi_collector_acc.sv
// Combinational combine step f(acc, x) for the collector accumulator.
module tms_acc_unit
    import tms_multi_collector_types::*;
#(
    parameter int DATA_W   = 32,
    parameter int ACC_MODE = ACC_WRAP
) (
    input  logic [DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0] x_in,
    output logic [DATA_W-1:0] acc_out
);

    logic [DATA_W:0] sum_ext;

    // One extra bit on the sum exposes the carry used for saturation.
    always_comb begin
        sum_ext = {1'b0, acc_in} + {1'b0, x_in};
        acc_out = sum_ext[DATA_W-1:0];
        case (ACC_MODE)
            ACC_SAT: begin
                if (sum_ext[DATA_W]) begin
                    acc_out = '1;
                end
            end
            ACC_MAX: begin
                acc_out = (x_in > acc_in) ? x_in : acc_in;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/tms_multi_collector.sv
// Reads NUM_CH blocking slave channels in order, combines them, and emits
// one result per frame with a single-cycle notify.
module tms_multi_collector
    import tms_multi_collector_types::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DATA_W        = 32,
    parameter int ACC_MODE      = ACC_WRAP,
    parameter int CLEAR_ON_EMIT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  s_in,
    input  logic [NUM_CH-1:0]              s_in_sync,
    input  logic [NUM_CH-1:0]              ch_enable,
    output logic [DATA_W-1:0]              m_out,
    output logic                           m_out_notify,
    output sections_t                      section_out,
    output logic [15:0]                    frame_cnt
);

    localparam int IDX_W = idx_width(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    sections_t         section_q, section_d;
    logic [IDX_W-1:0]  ch_idx_q, ch_idx_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [DATA_W-1:0] m_out_q, m_out_d;
    logic              notify_q, notify_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic [DATA_W-1:0] cur_data;
    logic [DATA_W-1:0] acc_next;

    // Handshake: a channel transfers on an A-cycle edge where it is the
    // current channel, enabled and s_in_sync is high; otherwise a disabled
    // channel is skipped and an enabled, non-ready one stalls the frame.
    assign cur_data = s_in[ch_idx_q];

    tms_acc_unit #(
        .DATA_W   (DATA_W),
        .ACC_MODE (ACC_MODE)
    ) u_acc (
        .acc_in  (val_q),
        .x_in    (cur_data),
        .acc_out (acc_next)
    );

    // Next-state and output logic of the section FSM.
    always_comb begin
        section_d   = section_q;
        ch_idx_d    = ch_idx_q;
        val_d       = val_q;
        m_out_d     = m_out_q;
        notify_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (section_q)
            SECTION_A: begin
                if (!ch_enable[ch_idx_q] || s_in_sync[ch_idx_q]) begin
                    if (ch_enable[ch_idx_q]) begin
                        val_d = acc_next;
                    end
                    if (ch_idx_q == LAST_IDX) begin
                        section_d = SECTION_B;
                    end else begin
                        ch_idx_d = ch_idx_q + 1'b1;
                    end
                end
            end
            SECTION_B: begin
                m_out_d     = val_q;
                notify_d    = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                ch_idx_d    = '0;
                if (CLEAR_ON_EMIT != 0) begin
                    val_d = '0;
                end
                section_d   = SECTION_A;
            end
            default: begin
                section_d = SECTION_A;
            end
        endcase
    end

    // State registers; reset discards any partially collected frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            section_q   <= SECTION_A;
            ch_idx_q    <= '0;
            val_q       <= '0;
            m_out_q     <= '0;
            notify_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            section_q   <= section_d;
            ch_idx_q    <= ch_idx_d;
            val_q       <= val_d;
            m_out_q     <= m_out_d;
            notify_q    <= notify_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_out        = m_out_q;
    assign m_out_notify = notify_q;
    assign section_out  = section_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_tms_multi_collector.sv
// Bench for tms_multi_collector: three instances (wrap/clear, sat/clear,
// max/carry) share one stimulus stream and are checked against a frame model.
module tb_tms_multi_collector;
    import tms_multi_collector_types::*;

    localparam int NCH = 4;
    localparam int ND  = 3;
    localparam int MODE_OF  [ND] = '{0, 1, 2};
    localparam int CLEAR_OF [ND] = '{1, 1, 0};

    logic                clk;
    logic                rst;
    logic [NCH-1:0][7:0] s_in;
    logic [NCH-1:0]      s_in_sync;
    logic [NCH-1:0]      ch_enable;
    logic [7:0]          m_out_w  [ND];
    logic                notify_w [ND];
    sections_t           sec_w    [ND];
    logic [15:0]         fc_w     [ND];

    int errors = 0;
    int checks = 0;

    // frame stimulus
    int         fr_vals  [NCH];
    int         fr_stall [NCH];
    logic [3:0] fr_en;
    // observations captured by the frame driver
    int         obs_first  [ND];
    int         obs_pulses [ND];
    int         obs_mout   [ND];
    int         obs_fc     [ND];
    int         obs_mfirst [ND];
    sections_t  obs_sec_pre[ND];
    sections_t  obs_sec_end[ND];
    // reference model state
    int         model_acc  [ND];
    int         model_mout [ND];
    int         model_fc   [ND];
    int         prev_mout  [ND];
    logic [7:0] exp_q[$];

    tms_multi_collector #(.NUM_CH(NCH), .DATA_W(8), .ACC_MODE(0), .CLEAR_ON_EMIT(1)) dut0 (
        .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .ch_enable(ch_enable),
        .m_out(m_out_w[0]), .m_out_notify(notify_w[0]), .section_out(sec_w[0]), .frame_cnt(fc_w[0]));
    tms_multi_collector #(.NUM_CH(NCH), .DATA_W(8), .ACC_MODE(1), .CLEAR_ON_EMIT(1)) dut1 (
        .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .ch_enable(ch_enable),
        .m_out(m_out_w[1]), .m_out_notify(notify_w[1]), .section_out(sec_w[1]), .frame_cnt(fc_w[1]));
    tms_multi_collector #(.NUM_CH(NCH), .DATA_W(8), .ACC_MODE(2), .CLEAR_ON_EMIT(0)) dut2 (
        .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .ch_enable(ch_enable),
        .m_out(m_out_w[2]), .m_out_notify(notify_w[2]), .section_out(sec_w[2]), .frame_cnt(fc_w[2]));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame result from the rules: fold the enabled channels in order.
    function automatic int model_fold(input int mode, input int acc, input int vals[NCH],
                                      input logic [3:0] en);
        int a;
        a = acc;
        for (int k = 0; k < NCH; k++) begin
            if (en[k]) begin
                case (mode)
                    0:       a = (a + vals[k]) % 256;
                    1:       a = (a + vals[k] > 255) ? 255 : a + vals[k];
                    default: a = (vals[k] > a) ? vals[k] : a;
                endcase
            end
        end
        return a;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            model_acc[d] = 0; model_mout[d] = 0; model_fc[d] = 0;
        end
    endtask

    task automatic model_emit();
        for (int d = 0; d < ND; d++) begin
            prev_mout[d]  = model_mout[d];
            model_mout[d] = model_fold(MODE_OF[d], model_acc[d], fr_vals, fr_en);
            model_fc[d]   = (model_fc[d] + 1) % 65536;
            model_acc[d]  = (CLEAR_OF[d] != 0) ? 0 : model_mout[d];
        end
    endtask

    // Driver: runs one frame of NCH + stalls + 1 edges. The current channel
    // sees its data/enable and a sync that is low for its stall cycles; every
    // other channel gets random data, sync and enable.
    task automatic run_frame();
        int sch_ch[$];
        bit sch_st[$];
        int total;
        int k;
        for (int c = 0; c < NCH; c++) begin
            if (fr_en[c]) begin
                for (int s = 0; s < fr_stall[c]; s++) begin
                    sch_ch.push_back(c); sch_st.push_back(1'b1);
                end
            end
            sch_ch.push_back(c); sch_st.push_back(1'b0);
        end
        total = sch_ch.size() + 1;
        for (int d = 0; d < ND; d++) begin
            obs_first[d] = 0; obs_pulses[d] = 0;
        end
        for (int e = 1; e <= total; e++) begin
            for (int c = 0; c < NCH; c++) s_in[c] = 8'($urandom);
            s_in_sync = 4'($urandom);
            ch_enable = 4'($urandom);
            if (e < total) begin
                k = sch_ch[e-1];
                s_in[k]      = 8'(fr_vals[k]);
                ch_enable[k] = fr_en[k];
                s_in_sync[k] = !sch_st[e-1];
            end
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++) begin
                if (notify_w[d]) begin
                    obs_pulses[d]++;
                    if (obs_first[d] == 0) obs_first[d] = e;
                end
                if (e == 1) obs_mfirst[d] = int'(m_out_w[d]);
                if (e == total - 1) obs_sec_pre[d] = sec_w[d];
                if (e == total) begin
                    obs_mout[d] = int'(m_out_w[d]);
                    obs_fc[d]   = int'(fc_w[d]);
                    obs_sec_end[d] = sec_w[d];
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < NCH; c++) s_in[c] = 8'($urandom);
            s_in_sync = 4'($urandom);
            ch_enable = 4'($urandom);
            @(posedge clk); #1;
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (m_out_w[d] !== 8'd0 || notify_w[d] !== 1'b0 || fc_w[d] !== 16'd0 ||
                sec_w[d] !== SECTION_A) begin
                errors++;
                $display("FAIL reset dut%0d: m_out=%0d notify=%b frame_cnt=%0d section=%0d, required 0/0/0/A",
                         d, m_out_w[d], notify_w[d], fc_w[d], sec_w[d]);
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        fr_vals = '{1, 2, 3, 4}; fr_stall = '{0, 0, 0, 0}; fr_en = 4'b1111;
        run_frame();
        model_emit();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_first[d] != 5 || obs_pulses[d] != 1) begin
                errors++;
                $display("FAIL basic_latency dut%0d: notify at edge %0d (%0d pulses), required edge 5 once",
                         d, obs_first[d], obs_pulses[d]);
            end
            checks++;
            if (obs_mout[d] != model_mout[d] || obs_fc[d] != model_fc[d]) begin
                errors++;
                $display("FAIL basic_result dut%0d: m_out=%0d frame_cnt=%0d, required %0d/%0d",
                         d, obs_mout[d], obs_fc[d], model_mout[d], model_fc[d]);
            end
            checks++;
            if (obs_sec_pre[d] !== SECTION_B || obs_sec_end[d] !== SECTION_A) begin
                errors++;
                $display("FAIL basic_section dut%0d: before emit %0d, after emit %0d, required B then A",
                         d, obs_sec_pre[d], obs_sec_end[d]);
            end
        end
        checks++;
        if (obs_mout[0] != 10) begin
            errors++;
            $display("FAIL basic_sum: m_out=%0d, required 10", obs_mout[0]);
        end
    endtask

    task automatic test_overflow();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) fr_vals = '{200, 100, 0, 0};
            else        fr_vals = '{1, 1, 1, 1};
            fr_stall = '{0, 0, 0, 0}; fr_en = 4'b1111;
            run_frame();
            model_emit();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (obs_mout[d] != model_mout[d] || obs_first[d] != 5) begin
                    errors++;
                    $display("FAIL overflow_f%0d dut%0d: m_out=%0d at edge %0d, required %0d at edge 5",
                             f, d, obs_mout[d], obs_first[d], model_mout[d]);
                end
                checks++;
                if (obs_mfirst[d] != prev_mout[d]) begin
                    errors++;
                    $display("FAIL overflow_hold dut%0d: m_out=%0d during frame, required %0d",
                             d, obs_mfirst[d], prev_mout[d]);
                end
            end
        end
    endtask

    task automatic test_max_carry();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) fr_vals = '{7, 200, 3, 9};
            else        fr_vals = '{5, 5, 5, 5};
            fr_stall = '{0, 0, 0, 0}; fr_en = 4'b1111;
            run_frame();
            model_emit();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (obs_mout[d] != model_mout[d]) begin
                    errors++;
                    $display("FAIL max_carry_f%0d dut%0d: m_out=%0d, required %0d",
                             f, d, obs_mout[d], model_mout[d]);
                end
            end
            checks++;
            if (obs_mout[2] != 200) begin
                errors++;
                $display("FAIL max_carry_const f%0d: m_out=%0d, required 200", f, obs_mout[2]);
            end
        end
    endtask

    task automatic test_stall();
        fr_vals = '{1, 2, 3, 4}; fr_stall = '{0, 3, 0, 0}; fr_en = 4'b1111;
        run_frame();
        model_emit();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_first[d] != 8 || obs_pulses[d] != 1 || obs_mout[d] != model_mout[d]) begin
                errors++;
                $display("FAIL stall dut%0d: m_out=%0d at edge %0d (%0d pulses), required %0d at edge 8 once",
                         d, obs_mout[d], obs_first[d], obs_pulses[d], model_mout[d]);
            end
        end
    endtask

    task automatic test_enable_mask();
        for (int f = 0; f < 2; f++) begin
            fr_vals = '{5, 99, 6, 99}; fr_stall = '{0, 0, 0, 0};
            fr_en = (f == 0) ? 4'b0101 : 4'b0000;
            run_frame();
            model_emit();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (obs_first[d] != 5 || obs_pulses[d] != 1 || obs_mout[d] != model_mout[d]) begin
                    errors++;
                    $display("FAIL enable_%0d dut%0d: m_out=%0d at edge %0d (%0d pulses), required %0d at edge 5 once",
                             f, d, obs_mout[d], obs_first[d], obs_pulses[d], model_mout[d]);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        s_in[0] = 8'd9; s_in[1] = 8'd8; s_in[2] = 8'd7; s_in[3] = 8'd6;
        s_in_sync = 4'b1111; ch_enable = 4'b1111;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (m_out_w[d] !== 8'd0 || notify_w[d] !== 1'b0 || fc_w[d] !== 16'd0 ||
                sec_w[d] !== SECTION_A) begin
                errors++;
                $display("FAIL midreset dut%0d: m_out=%0d notify=%b frame_cnt=%0d section=%0d, required 0/0/0/A",
                         d, m_out_w[d], notify_w[d], fc_w[d], sec_w[d]);
            end
        end
        fr_vals = '{1, 1, 1, 1}; fr_stall = '{0, 0, 0, 0}; fr_en = 4'b1111;
        run_frame();
        model_emit();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_mout[d] != model_mout[d] || obs_fc[d] != 1 || obs_pulses[d] != 1) begin
                errors++;
                $display("FAIL post_reset dut%0d: m_out=%0d frame_cnt=%0d pulses=%0d, required %0d/1/1",
                         d, obs_mout[d], obs_fc[d], obs_pulses[d], model_mout[d]);
            end
        end
    endtask

    task automatic test_random();
        int exp_edges;
        logic [7:0] exp_v;
        for (int f = 0; f < 8; f++) begin
            exp_edges = NCH + 1;
            fr_en = 4'($urandom);
            for (int c = 0; c < NCH; c++) begin
                fr_vals[c]  = $urandom_range(0, 255);
                fr_stall[c] = $urandom_range(0, 2);
                if (fr_en[c]) exp_edges += fr_stall[c];
            end
            run_frame();
            model_emit();
            for (int d = 0; d < ND; d++) exp_q.push_back(8'(model_mout[d]));
            for (int d = 0; d < ND; d++) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (obs_mout[d] != int'(exp_v) || obs_first[d] != exp_edges ||
                    obs_fc[d] != model_fc[d]) begin
                    errors++;
                    $display("FAIL random_f%0d dut%0d: m_out=%0d edge=%0d frame_cnt=%0d, required %0d/%0d/%0d",
                             f, d, obs_mout[d], obs_first[d], obs_fc[d], exp_v, exp_edges, model_fc[d]);
                end
            end
        end
    endtask

    // test sequence and final report
    initial begin
        rst = 1'b1;
        s_in = '0;
        s_in_sync = '0;
        ch_enable = '0;
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_max_carry();
        test_stall();
        test_enable_mask();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
